// File: rtl/mem_responder.sv
// mem_responder: memory-side responder with programmable wait states for a unified I/D memory port.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   req            access request, sampled only while idle
//   we             1 = write, 0 = read (captured with req)
//   addr[31:0]     byte address (captured with req), word index = addr[DEPTH_LOG2+1:2]
//   wdata[31:0]    write data (captured with req)
//   rdata[31:0]    registered read data, valid with ready, held until the next read response
//   ready          one-cycle completion pulse
//   busy           high whenever an access is in flight
//   err            misaligned-access flag, valid with ready
//
// Optional feature: define MEM_RESPONDER_ALIGN_CHECK_EN to flag misaligned accesses
// (write suppressed, read returns 0, err=1). Without it err is constant 0.
module mem_responder #(
    parameter int DEPTH_LOG2 = 6,
    parameter int WAIT       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  mis_q, mis_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] idx_in;
    logic                  mis_in;
    logic                  unused_addr_bits;

    assign idx_in = addr[DEPTH_LOG2+1:2];
    // Upper bits alias the memory; the low two only matter with the alignment check.
    assign unused_addr_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    assign mis_in = addr[1:0] != 2'b00;
`else
    assign mis_in = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        mis_d   = mis_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = we;
                    idx_d   = idx_in;
                    wdata_d = wdata;
                    mis_d   = mis_in;
                    state_d = (WAIT == 0) ? ST_RESP : ST_WAIT;
                    cnt_d   = 4'(WAIT);
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd1) state_d = ST_RESP;
                else cnt_d = cnt_q - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
        // Response outputs are registered on the edge entering RESP; the d-side
        // capture values cover the zero-wait path straight out of IDLE.
        if (state_d == ST_RESP && state_q != ST_RESP) begin
            ready_d = 1'b1;
            err_d   = mis_d;
            if (!we_d) rdata_d = mis_d ? 32'h0 : mem[idx_d];
        end
        busy_d = state_d != ST_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            mis_q   <= 1'b0;
            rdata_q <= 32'h0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Write commits on the edge leaving RESP; an async reset drops the state to
    // IDLE first, so an abandoned write never lands. Contents are not reset.
    always_ff @(posedge clk) begin
        if (state_q == ST_RESP && we_q && !mis_q) mem[idx_q] <= wdata_q;
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign err   = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed plus random checks of mem_responder against a word-array model.
module tb_mem_responder;
    localparam int WAIT = 2;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we;
    logic [31:0] addr, wdata, rdata;
    logic        ready, busy, err;
    logic        req0, we0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        ready0, busy0, err0;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] model [64];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_LOG2(6), .WAIT(WAIT)) u_dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .busy(busy), .err(err)
    );

    mem_responder #(.DEPTH_LOG2(6), .WAIT(0)) u_dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in an idle cycle; returns at the negedge of the idle cycle after RESP.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic        mis;
        logic [5:0]  i;
        logic [31:0] exp_rd;
        mis    = ALIGN && (a[1:0] != 2'b00);
        i      = a[7:2];
        exp_rd = w ? last_rd : (mis ? 32'h0 : model[i]);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom;
        for (int k = 1; k <= WAIT; k++) begin
            if (k > 1) @(negedge clk);
            check("wait_ready", ready, 0);
            check("wait_busy", busy, 1);
        end
        @(negedge clk);
        check("resp_ready", ready, 1);
        check("resp_busy", busy, 1);
        check("resp_err", err, 32'(mis));
        check("resp_rdata", rdata, exp_rd);
        @(negedge clk);
        check("idle_ready", ready, 0);
        check("idle_busy", busy, 0);
        check("idle_rdata_hold", rdata, exp_rd);
        last_rd = exp_rd;
        if (w && !mis) model[i] = d;
    endtask

    task automatic access0(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd);
        req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        @(posedge clk);
        @(negedge clk);
        req0 = 1'b0;
        check("w0_ready", ready0, 1);
        check("w0_busy", busy0, 1);
        check("w0_err", err0, 0);
        if (!w) check("w0_rdata", rdata0, exp_rd);
        @(negedge clk);
        check("w0_idle_ready", ready0, 0);
        check("w0_idle_busy", busy0, 0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d0;
        reset = 1'b1;
        req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
        last_rd = 32'h0;
        @(posedge clk);
        #1;
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 64; i++) access(1'b1, 32'(i * 4), $urandom);
        access(1'b1, 32'h10, 32'hDEADBEEF);
        access(1'b0, 32'h10, 32'h0);
        access(1'b1, 32'h0000_0104, 32'h12345678);
        access(1'b0, 32'h0000_0004, 32'h0);
        access(1'b1, 32'h13, 32'hFFFFFFFF);
        access(1'b0, 32'h10, 32'h0);
        access(1'b1, 32'h10, 32'hDEADBEEF);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hA5A5A5A5;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_ready", ready, 0);
        check("abort_rdata", rdata, 0);
        @(negedge clk);
        check("abort_no_ready", ready, 0);
        reset = 1'b0;
        last_rd = 32'h0;
        @(negedge clk);
        access(1'b0, 32'h20, 32'h0);
        req = 1'b1; we = 1'b0; addr = 32'h10; wdata = 32'h0;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("cont_ready", ready, 32'(k % (WAIT + 2) == WAIT + 1));
            check("cont_busy", busy, 32'(k % (WAIT + 2) != 0));
            if (k % (WAIT + 2) == WAIT + 1) check("cont_rdata", rdata, model[4]);
        end
        req = 1'b0;
        last_rd = model[4];
        @(negedge clk);
        check("cont_stop_busy", busy, 0);
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            access(1'($urandom_range(0, 1)), a, $urandom);
        end
        d0 = $urandom;
        access0(1'b1, 32'h40, d0, 32'h0);
        access0(1'b0, 32'h1000_0040, 32'h0, d0);
        access0(1'b1, 32'h44, ~d0, 32'h0);
        access0(1'b0, 32'h44, 32'h0, ~d0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multi-cycle processor's unified instruction/data memory port. It accepts one read or write request at a time from the controller/datapath and services it after a programmable number of wait states. It signals completion with a one-cycle `ready` pulse carrying the read data. It lets the fetch and memory-access states of the processor run against a memory that is not single-cycle.

## Interface
- `DEPTH_LOG2`, 6: log2 of word count (64 words, 256 bytes).
- `WAIT`, 2: wait-state cycles inserted per access (legal range 0..15).

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  1  access request; sampled only in IDLE.
- `we`  in  1  1 = write, 0 = read; captured with `req`.
- `addr`  in  32  byte address; captured with `req`.
- `wdata`  in  32  write data; captured with `req`.
- `rdata`  out  32  read data, registered; valid while `ready`=1, held until the next read response.
- `ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high whenever state ≠ IDLE.
- `err`  out  1  misaligned-access flag, valid with `ready` (see Configuration).

## Operation
- Storage: 2^DEPTH_LOG2 × 32-bit words. Word index = `addr[DEPTH_LOG2+1:2]`. Upper address bits are ignored, so the memory aliases and wraps modulo 256 bytes at the default depth.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if `req`=1, capture `we`/`addr`/`wdata`. Go to WAIT with `cnt`=WAIT, or to RESP directly if WAIT=0. If `req`=0, stay in IDLE.
  - WAIT: if `cnt`==1, go to RESP; otherwise decrement `cnt`. Exactly WAIT cycles are spent here.
  - RESP: `ready`=1 for this single cycle, then go unconditionally to IDLE.
- Read: `rdata` is loaded from the captured word on the edge entering RESP.
- Write: the memory word is updated on the edge leaving RESP. `rdata` is unchanged by writes.
- `req` is ignored outside IDLE. A `req` still high in the IDLE cycle after RESP is accepted as a new request. The requester drops `req` on seeing `ready` if it wants a single access.
- Write-then-read to the same word returns the new data. There is no hazard, because the write commits before IDLE.
- Memory contents are not reset and are undefined at power-up.

## Timing
- Request accepted on edge T (IDLE, `req`=1). `ready` is high during cycle T+WAIT+1.
- Minimum request-to-request spacing is WAIT+2 cycles, because at least one IDLE cycle follows each RESP.
- `busy` rises the cycle after acceptance and falls after the RESP cycle.
- Reset values: state IDLE, `cnt`=0, `ready`=0, `busy`=0, `err`=0, `rdata`=0.
- Reset mid-access (WAIT or RESP): the transaction is abandoned. No `ready` pulse, and a pending write is not committed. `rdata` clears to 0.

## Configuration
- `MEM_RESPONDER_ALIGN_CHECK_EN` defined:
  - A captured `addr[1:0]`≠0 completes with normal latency, `ready`=1 and `err`=1.
  - A misaligned write is suppressed.
  - A misaligned read returns `rdata`=0.
  - `err` is 0 on all aligned responses and outside RESP.
- Macro undefined: `addr[1:0]` is ignored, so accesses act on the containing word. `err` is tied to 0.

## Test plan
- WAIT=2. After reset, write `addr`=0x10, `wdata`=0xDEADBEEF, accepted at edge 0 → `ready` high in cycle 3, `busy` high cycles 1–3. A following read of 0x10 → `ready` with `rdata`=0xDEADBEEF.
- Alias: write 0x0000_0104 ← 0x12345678, then read 0x0000_0004 → `rdata`=0x12345678.
- With macro: write 0x13 ← 0xFFFFFFFF over existing 0xDEADBEEF at 0x10 → `ready`=1, `err`=1. A read of 0x10 still returns 0xDEADBEEF with `err`=0. Without macro, the same write makes a read of 0x10 return 0xFFFFFFFF.
- Assert `reset` in the first WAIT cycle of a write to 0x20 ← 0xA5A5A5A5 → no `ready`, `busy`=0 immediately. A later read of 0x20 returns its prior value.
- `req` held high continuously with `we`=0 → `ready` pulses every WAIT+2 = 4 cycles, and `busy` is low exactly one cycle between pulses.
- WAIT=0: read accepted at edge 0 → `ready` high in cycle 1, WAIT state never entered.
